// File: rtl/rr_channel_mux.sv
// rr_channel_mux: N-channel registered multiplexer with valid/ready handshakes.
// Selects one producer channel per cycle, either a fixed channel (mode = 0) or by
// round-robin scan (mode = 1). It captures the word into a single output register
// tagged with its source channel.
module rr_channel_mux #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_out_chan;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load_en;
    logic                w_grant_valid;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [SEL_W-1:0]    w_scan_idx;
    logic [CHANNELS-1:0] w_in_ready;
    logic [WIDTH-1:0]    w_grant_data;

    // The output register can take a word when it is empty or being drained this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Grant selection: fixed channel or first valid channel scanning upward from r_ptr.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = {SEL_W{1'b0}};
        w_scan_idx    = {SEL_W{1'b0}};
        if (w_load_en && !reset) begin
            if (!mode) begin
                if (in_valid[sel]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = sel;
                end else begin
                    w_grant_valid = 1'b0;
                end
            end else begin
                // CHANNELS is a power of two, so SEL_W-bit addition wraps naturally.
                for (int i = 0; i < CHANNELS; i++) begin
                    w_scan_idx = r_ptr + SEL_W'(i);
                    if (!w_grant_valid && in_valid[w_scan_idx]) begin
                        w_grant_valid = 1'b1;
                        w_grant_idx   = w_scan_idx;
                    end else begin
                        w_grant_valid = w_grant_valid;
                    end
                end
            end
        end else begin
            w_grant_valid = 1'b0;
        end
    end

    // One-hot ready toward the granted producer only; all-zero otherwise.
    always_comb begin
        w_in_ready = {CHANNELS{1'b0}};
        if (w_grant_valid) begin
            w_in_ready[w_grant_idx] = 1'b1;
        end else begin
            w_in_ready = {CHANNELS{1'b0}};
        end
    end

    assign in_ready     = w_in_ready;
    assign w_grant_data = in_data[w_grant_idx*WIDTH +: WIDTH];

    // Output register, channel tag and round-robin pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_out_chan  <= {SEL_W{1'b0}};
            r_ptr       <= {SEL_W{1'b0}};
        end else if (w_grant_valid) begin
            // A grant implies in_valid[g] & in_ready[g]: the transfer happens here.
            r_out_data  <= w_grant_data;
            r_out_chan  <= w_grant_idx;
            r_out_valid <= 1'b1;
            if (mode) begin
                r_ptr <= w_grant_idx + SEL_W'(1);
            end else begin
                r_ptr <= r_ptr;
            end
        end else if (r_out_valid && out_ready) begin
            // Drain with no replacement: data and tag keep their last values.
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;

endmodule
